prefetch_fetch_stage: RTL and testbench

PREFETCH_FETCH_STAGE -- requirements
Module: prefetch_fetch_stage

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_queue.sv | 67 ++++++
 rtl/prefetch_fetch_stage.sv | 99 +++++++++
 tb/tb_prefetch_fetch_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the prefetching instruction-fetch stage: default
// widths, the PC step, and the fetch-queue entry layout.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;
    localparam int unsigned ILEN_DEFAULT = 32;
    localparam int unsigned PC_INCR      = 4;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [ILEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous DEPTH-entry FIFO holding fetched {pc, instr} entries.
// Flush empties it in one cycle. The head is presented combinationally
// and reads as zero when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  entry_t                   push_data_i,
    input  logic                     pop_i,
    output logic                     out_valid_o,
    output entry_t                   out_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    entry_t        mem_q [DEPTH];

    logic do_push, do_pop;

    // Qualify requests so the pointers can never run past each other.
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;
    assign do_push = push_i && ((count_q != FULL) || do_pop) && !flush_i;

    // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage written at the tail.
    // NOTE: storage has no reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o     = count_q;

endmodule

// File: rtl/prefetch_fetch_stage.sv
// Prefetching fetch stage: issues sequential instruction-memory reads while
// the queue plus the in-flight response still fit, buffers responses in a
// small FIFO, and hands them to decode with a valid/ready handshake.
// A redirect flushes everything and restarts fetch at the aligned target.
module prefetch_fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned    XLEN     = XLEN_DEFAULT,
    parameter int unsigned    ILEN     = ILEN_DEFAULT,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic [ILEN-1:0]         imem_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [ILEN-1:0]         out_instr,
    output logic [$clog2(DEPTH):0]  queue_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;

    logic   [CW:0]   occupancy;
    logic            push, pop;
    entry_t          push_data, head;

    // Count the response already on its way so it always has a free slot.
    assign occupancy = {1'b0, queue_count} + {{CW{1'b0}}, inflight_q};
    assign imem_req  = rst && !redirect_valid && (occupancy < DEPTH_W);
    assign imem_addr = fetch_pc_q;

    // A redirect drops the response that arrives in its cycle and blocks any pop.
    assign push            = inflight_q && !redirect_valid;
    assign pop             = out_valid && out_ready && !redirect_valid;
    assign push_data.pc    = req_pc_q;
    assign push_data.instr = imem_rdata;

    // Next fetch address, in-flight flag and captured request PC.
    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = imem_req;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
        end else if (imem_req) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_INCR);
            req_pc_d   = fetch_pc_q;
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_queue #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .out_valid_o (out_valid),
        .out_data_o  (head),
        .count_o     (queue_count)
    );

    assign out_pc    = head.pc;
    assign out_instr = head.instr;

endmodule

// File: tb/tb_prefetch_fetch_stage.sv
// Directed bench for prefetch_fetch_stage (XLEN 64, ILEN 32, DEPTH 4, RESET_PC 0).
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_prefetch_fetch_stage;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  queue_count;

    int checks = 0;
    int errors = 0;

    prefetch_fetch_stage #(
        .XLEN     (64),
        .ILEN     (32),
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .queue_count    (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: answers the request seen in a cycle during the next cycle.
    logic        pend_req;
    logic [63:0] pend_addr;
    always @(negedge clk) begin
        pend_req  = imem_req;
        pend_addr = imem_addr;
    end
    always @(posedge clk) begin
        #1;
        imem_rdata = pend_req ? instr_of(pend_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_pc;
        int          pops;
        logic        req_d1, req_d2, prev_fire, fire;
        logic [2:0]  cnt_prev;

        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;

        // Reset state
        #3;
        check("rst_req",   imem_req,    0);
        check("rst_valid", out_valid,   0);
        check("rst_pc",    out_pc,      0);
        check("rst_instr", out_instr,   0);
        check("rst_count", queue_count, 0);
        check("rst_addr",  imem_addr,   0);
        settle();

        // Release with out_ready = 1: one instruction per cycle
        next_cycle(); rst = 1'b1; settle();
        check("c0_req", imem_req, 1);
        check("c0_addr", imem_addr, 64'h0);
        next_cycle(); settle();
        check("c1_addr", imem_addr, 64'h4);
        check("c1_valid", out_valid, 0);
        next_cycle(); settle();
        check("c2_addr", imem_addr, 64'h8);
        check("c2_valid", out_valid, 1);
        check("c2_pc", out_pc, 64'h0);
        check("c2_instr", out_instr, instr_of(64'h0));
        next_cycle(); settle();
        check("c3_pc", out_pc, 64'h4);
        check("c3_count", queue_count, 1);
        next_cycle(); settle();
        check("c4_pc", out_pc, 64'h8);

        // Reset again, then out_ready = 0: queue fills with exactly four requests
        next_cycle(); rst = 1'b0; out_ready = 1'b0; settle();
        check("d_rst_req", imem_req, 0);
        next_cycle(); rst = 1'b1; settle();
        check("d0_req", imem_req, 1);
        check("d0_addr", imem_addr, 64'h0);
        for (int i = 1; i < 4; i++) begin
            next_cycle(); settle();
            check("dn_req", imem_req, 1);
            check("dn_addr", imem_addr, 64'(4 * i));
        end
        next_cycle(); settle();
        check("d4_req", imem_req, 0);
        check("d4_count", queue_count, 3);
        next_cycle(); settle();
        check("d5_count", queue_count, 4);
        check("d5_req", imem_req, 0);
        check("d5_valid", out_valid, 1);
        check("d5_pc", out_pc, 64'h0);
        check("d5_addr", imem_addr, 64'h10);
        next_cycle(); settle();
        check("d6_count", queue_count, 4);
        check("d6_pc", out_pc, 64'h0);
        check("d6_instr", out_instr, instr_of(64'h0));

        // Redirect with three entries queued and a response in flight
        next_cycle(); out_ready = 1'b1; settle();
        check("e0_req", imem_req, 0);
        next_cycle(); out_ready = 1'b0; settle();
        check("e1_count", queue_count, 3);
        check("e1_req", imem_req, 1);
        check("e1_addr", imem_addr, 64'h10);
        check("e1_pc", out_pc, 64'h4);
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h1002; out_ready = 1'b1; settle();
        check("e2_req", imem_req, 0);
        next_cycle(); redirect_valid = 1'b0; settle();
        check("e3_count", queue_count, 0);
        check("e3_valid", out_valid, 0);
        check("e3_req", imem_req, 1);
        check("e3_addr", imem_addr, 64'h1000);
        next_cycle(); settle();
        check("e4_addr", imem_addr, 64'h1004);
        check("e4_valid", out_valid, 0);
        next_cycle(); settle();
        check("e5_valid", out_valid, 1);
        check("e5_pc", out_pc, 64'h1000);
        check("e5_instr", out_instr, instr_of(64'h1000));
        next_cycle(); settle();
        check("e6_pc", out_pc, 64'h1004);

        // Back-to-back redirects: the last one wins
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h2000; settle();
        check("bb0_req", imem_req, 0);
        next_cycle(); redirect_pc = 64'h3006; settle();
        check("bb1_req", imem_req, 0);
        check("bb1_count", queue_count, 0);
        next_cycle(); redirect_valid = 1'b0; settle();
        check("bb2_req", imem_req, 1);
        check("bb2_addr", imem_addr, 64'h3004);

        // Address wrap at the top of the address space
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF; settle();
        next_cycle(); redirect_valid = 1'b0; settle();
        check("w1_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        next_cycle(); settle();
        check("w2_addr", imem_addr, 64'h0);
        next_cycle(); settle();
        check("w3_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("w3_instr", out_instr, instr_of(64'hFFFF_FFFF_FFFF_FFFC));
        next_cycle(); settle();
        check("w4_pc", out_pc, 64'h0);

        // Fill from pc 0, then toggle out_ready and check order across pointer wrap
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h0; out_ready = 1'b0; settle();
        next_cycle(); redirect_valid = 1'b0; settle();
        repeat (5) begin
            next_cycle(); settle();
        end
        check("g_full_count", queue_count, 4);
        check("g_full_req", imem_req, 0);

        exp_pc    = 64'h0;
        pops      = 0;
        req_d1    = imem_req;
        req_d2    = 1'b0;
        prev_fire = 1'b0;
        cnt_prev  = queue_count;
        for (int k = 0; k < 100 && pops < 16; k++) begin
            next_cycle(); out_ready = (k % 2 == 0); settle();
            if (req_d2 && prev_fire) check("pushpop_count", queue_count, cnt_prev);
            fire = out_valid && out_ready;
            if (fire) begin
                check("order_pc", out_pc, exp_pc);
                check("order_instr", out_instr, instr_of(exp_pc));
                exp_pc = exp_pc + 64'h4;
                pops++;
            end
            req_d2    = req_d1;
            req_d1    = imem_req;
            prev_fire = fire;
            cnt_prev  = queue_count;
        end
        check("order_pops", pops, 16);

        // Asynchronous reset with two entries queued
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h500; out_ready = 1'b0; settle();
        next_cycle(); redirect_valid = 1'b0; settle();
        check("h1_addr", imem_addr, 64'h500);
        repeat (3) begin
            next_cycle(); settle();
        end
        check("h4_count", queue_count, 2);
        check("h4_pc", out_pc, 64'h500);
        #2; rst = 1'b0; #1;
        check("ar_valid", out_valid, 0);
        check("ar_pc", out_pc, 0);
        check("ar_instr", out_instr, 0);
        check("ar_count", queue_count, 0);
        check("ar_req", imem_req, 0);
        check("ar_addr", imem_addr, 64'h0);
        next_cycle(); rst = 1'b1; out_ready = 1'b1; settle();
        check("ar0_req", imem_req, 1);
        check("ar0_addr", imem_addr, 64'h0);
        next_cycle(); settle();
        check("ar1_valid", out_valid, 0);
        next_cycle(); settle();
        check("ar2_valid", out_valid, 1);
        check("ar2_pc", out_pc, 64'h0);
        check("ar2_instr", out_instr, instr_of(64'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
